// File: rtl/lru_pkg.sv
// lru_pkg: shared tree-PLRU encoding for lru_tree_update (writer) and
// eviction_lru (decoder).
//   Node 0 is the root. Node a has children 2a+1 (left, bit 0) and
//   2a+2 (right, bit 1). The root supplies the MSB of a way index.
//   The helpers work on maximum-width vectors. Callers zero-extend their
//   (ASSOCIATIVITY-1)-bit state into lru_bits_t and take the low bits of
//   the result.
package lru_pkg;

  localparam int unsigned LRU_MAX_LEVELS = 6;
  localparam int unsigned LRU_MAX_WAYS   = 1 << LRU_MAX_LEVELS;
  localparam logic [LRU_MAX_LEVELS-1:0] LRU_ROOT = '0;

  typedef logic [LRU_MAX_WAYS-2:0]   lru_bits_t;
  typedef logic [LRU_MAX_LEVELS-1:0] way_t;

  function automatic way_t lru_child(way_t node, logic dir);
    return {node[LRU_MAX_LEVELS-2:0], 1'b0} + way_t'(1) + way_t'(dir);
  endfunction

  // Points every node on the path of 'way' away from it.
  function automatic lru_bits_t plru_update(lru_bits_t bits, way_t way,
                                            int unsigned levels);
    lru_bits_t res;
    way_t      node;
    way_t      w;
    logic      b;
    res  = bits;
    node = LRU_ROOT;
    // Left-align the way so its MSB is always the top bit.
    w    = way << (LRU_MAX_LEVELS - levels);
    for (int k = 0; k < int'(LRU_MAX_LEVELS); k++) begin
      if (k < int'(levels)) begin
        b         = w[LRU_MAX_LEVELS-1];
        res[node] = ~b;
        node      = lru_child(node, b);
        w         = w << 1;
      end
    end
    return res;
  endfunction

  // Follows the stored bits from the root down to the victim leaf.
  function automatic way_t plru_victim(lru_bits_t bits, int unsigned levels);
    way_t victim;
    way_t node;
    logic b;
    victim = '0;
    node   = LRU_ROOT;
    for (int k = 0; k < int'(LRU_MAX_LEVELS); k++) begin
      if (k < int'(levels)) begin
        b      = bits[node];
        victim = {victim[LRU_MAX_LEVELS-2:0], b};
        node   = lru_child(node, b);
      end
    end
    return victim;
  endfunction

endpackage

// File: rtl/eviction_lru.sv
// eviction_lru: combinational tree-PLRU victim decoder.
//   lru_bits   : PLRU node bits of one set (node 0 = bit 0)
//   victim_way : way the tree currently points at
module eviction_lru
  import lru_pkg::*;
#(
  parameter int ASSOCIATIVITY = 8
) (
  input  logic [ASSOCIATIVITY-2:0]         lru_bits,
  output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way
);

  localparam int unsigned LEVELS = $clog2(ASSOCIATIVITY);

  way_t victim_wide;

  always_comb begin
    victim_wide = plru_victim(lru_bits_t'(lru_bits), LEVELS);
    victim_way  = victim_wide[LEVELS-1:0];
  end

endmodule

// File: rtl/lru_tree_update.sv
// lru_tree_update: per-set tree-PLRU state owner with victim lookup and a
// one-set-per-cycle flush.
//   upd_valid/upd_ready/upd_set/upd_way : access report (hit or fill)
//   vic_req/vic_set                     : victim lookup request
//   vic_valid/vic_way/vic_lru_bits      : registered lookup result (1 cycle)
//   flush/busy                          : start / in-progress of full clear
// Build option: LRU_UPD_FWD_EN forwards a same-edge update to a lookup of
// the same set. When it is undefined, that lookup sees the pre-update bits.
//
// state | meaning
// IDLE  | accepts updates and lookups, waits for flush
// FLUSH | clears set flush_ptr each cycle, 0..SETS-1
module lru_tree_update
  import lru_pkg::*;
#(
  parameter int ASSOCIATIVITY = 8,
  parameter int SETS          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             upd_valid,
  output logic                             upd_ready,
  input  logic [((SETS>1)?$clog2(SETS):1)-1:0] upd_set,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] upd_way,
  input  logic                             vic_req,
  input  logic [((SETS>1)?$clog2(SETS):1)-1:0] vic_set,
  output logic                             vic_valid,
  output logic [$clog2(ASSOCIATIVITY)-1:0] vic_way,
  output logic [ASSOCIATIVITY-2:0]         vic_lru_bits,
  input  logic                             flush,
  output logic                             busy
);

  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int NB    = ASSOCIATIVITY - 1;
  localparam logic [SET_W:0]   SET_LIMIT = (SET_W+1)'(SETS);
  localparam logic [SET_W-1:0] LAST_SET  = SET_W'(SETS - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [NB-1:0]    mem [SETS];
  logic [SET_W-1:0] flush_ptr;

  logic             upd_fire, vic_fire;
  logic             upd_in_range, vic_in_range;
  logic [NB-1:0]    upd_old_bits, upd_new_bits, rd_bits, sel_bits;
  lru_bits_t        upd_wide;
  logic [WAY_W-1:0] dec_way;

  always_comb begin
    state_d   = state_q;
    upd_ready = 1'b0;
    busy      = 1'b0;
    upd_fire  = 1'b0;
    vic_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        upd_ready = 1'b1;
        upd_fire  = upd_valid;
        vic_fire  = vic_req;
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_ptr == LAST_SET) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    upd_in_range = {1'b0, upd_set} < SET_LIMIT;
    vic_in_range = {1'b0, vic_set} < SET_LIMIT;
    upd_old_bits = upd_in_range ? mem[upd_set] : '0;
    upd_wide     = plru_update(lru_bits_t'(upd_old_bits), way_t'(upd_way), WAY_W);
    upd_new_bits = upd_wide[NB-1:0];
    rd_bits      = vic_in_range ? mem[vic_set] : '0;
`ifdef LRU_UPD_FWD_EN
    sel_bits = (upd_fire && upd_in_range && (upd_set == vic_set)) ? upd_new_bits : rd_bits;
`else
    sel_bits = rd_bits;
`endif
  end

  eviction_lru #(
    .ASSOCIATIVITY(ASSOCIATIVITY)
  ) u_dec (
    .lru_bits  (sel_bits),
    .victim_way(dec_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flush_ptr <= '0;
    end else begin
      state_q   <= state_d;
      flush_ptr <= (state_q == FLUSH) ? flush_ptr + 1'b1 : '0;
    end
  end

  // The flush clear has priority; an update can only fire in IDLE anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) mem[i] <= '0;
    end else if (state_q == FLUSH) begin
      mem[flush_ptr] <= '0;
    end else if (upd_fire && upd_in_range) begin
      mem[upd_set] <= upd_new_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vic_valid    <= 1'b0;
      vic_way      <= '0;
      vic_lru_bits <= '0;
    end else begin
      vic_valid <= vic_fire;
      if (vic_fire) begin
        vic_way      <= dec_way;
        vic_lru_bits <= sel_bits;
      end
    end
  end

endmodule

// File: tb/tb_lru_tree_update.sv
module tb_lru_tree_update;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [3:0] upd_set = '0;
  logic [2:0] upd_way = '0;
  logic       vic_req = 1'b0;
  logic [3:0] vic_set = '0;
  logic       vic_valid;
  logic [2:0] vic_way;
  logic [6:0] vic_lru_bits;
  logic       flush = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  lru_tree_update #(.ASSOCIATIVITY(8), .SETS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set), .upd_way(upd_way),
    .vic_req(vic_req), .vic_set(vic_set),
    .vic_valid(vic_valid), .vic_way(vic_way), .vic_lru_bits(vic_lru_bits),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [3:0] s, input logic [2:0] w);
    upd_valid = 1'b1; upd_set = s; upd_way = w;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [3:0] s,
                      input logic [6:0] eb, input logic [2:0] ew);
    vic_req = 1'b1; vic_set = s;
    step();
    vic_req = 1'b0;
    chk({tag, "_valid"}, vic_valid, 1);
    chk({tag, "_bits"}, vic_lru_bits, eb);
    chk({tag, "_way"}, vic_way, ew);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_upd_ready"}, upd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vic_valid"}, vic_valid, 0);
    chk({tag, "_vic_way"}, vic_way, 0);
    chk({tag, "_vic_bits"}, vic_lru_bits, 0);
  endtask

  initial begin
    int n;
    logic saw_valid;
    #2;
    chk_reset_outs("reset");
    #10 rst_n = 1'b1;
    step();

    look("rst_set3", 4'd3, 7'h00, 3'd0);
    step();
    chk("valid_one_cycle", vic_valid, 0);

    do_upd(4'd3, 3'd0);
    look("set3_w0", 4'd3, 7'h0B, 3'd4);
    do_upd(4'd3, 3'd4);
    look("set3_w4", 4'd3, 7'h2E, 3'd2);
    look("set2_untouched", 4'd2, 7'h00, 3'd0);

    // Same-edge update and lookup of set 5.
    upd_valid = 1'b1; upd_set = 4'd5; upd_way = 3'd0;
    vic_req = 1'b1; vic_set = 4'd5;
    step();
    upd_valid = 1'b0; vic_req = 1'b0;
`ifdef LRU_UPD_FWD_EN
    chk("fwd_bits", vic_lru_bits, 7'h0B);
    chk("fwd_way", vic_way, 3'd4);
`else
    chk("nofwd_bits", vic_lru_bits, 7'h00);
    chk("nofwd_way", vic_way, 3'd0);
`endif
    look("set5_landed", 4'd5, 7'h0B, 3'd4);

    for (int s = 0; s < 16; s++) do_upd(4'(s), 3'(s % 8));
    look("set1_w1", 4'd1, 7'h03, 3'd4);

    flush = 1'b1;
    step();
    flush = 1'b0;
    vic_req = 1'b1; vic_set = 4'd1;
    n = 0;
    saw_valid = 1'b0;
    while (busy && n < 40) begin
      if (upd_ready) saw_valid = 1'b1;
      if (vic_valid) saw_valid = 1'b1;
      n++;
      step();
    end
    vic_req = 1'b0;
    chk("flush_cycles", n, 16);
    chk("flush_no_valid_or_ready", saw_valid, 0);
    chk("flush_end_valid", vic_valid, 0);
    chk("flush_end_ready", upd_ready, 1);
    chk("flush_end_busy", busy, 0);
    for (int s = 0; s < 16; s++) look("post_flush", 4'(s), 7'h00, 3'd0);

    do_upd(4'd3, 3'd0);
    do_upd(4'd9, 3'd2);
    do_upd(4'd14, 3'd5);
    look("set9_w2", 4'd9, 7'h11, 3'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush2_busy", busy, 1);
    chk("flush2_ready", upd_ready, 0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midflush_rst");
    #2 rst_n = 1'b1;
    step();
    chk("after_rst_ready", upd_ready, 1);
    look("rst_set3_clr", 4'd3, 7'h00, 3'd0);
    look("rst_set9_clr", 4'd9, 7'h00, 3'd0);
    look("rst_set14_clr", 4'd14, 7'h00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
